// File: rtl/plot_readback.sv
// Pixel-plot sink: 160x120x3 framebuffer written by vga_* strobes, dumped in raster order over valid/ready.
// Optional PLOT_READBACK_COUNT_EN adds a saturating in-range plot counter (plot_count).
module plot_readback #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       start,
  output logic       done,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       oob_err
`ifdef PLOT_READBACK_COUNT_EN
  ,
  output logic [14:0] plot_count
`endif
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = 15;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  logic [2:0] fb_mem [0:DEPTH-1];
  logic [2:0] rd_dat_q;

  state_t      state_q, state_d;
  logic [7:0]  rd_x_q, rd_x_d;
  logic [6:0]  rd_y_q, rd_y_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic        rd_all_q, rd_all_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_x_q, pend_x_d;
  logic [6:0]  pend_y_q, pend_y_d;
  logic        skid_vld_q, skid_vld_d;
  logic [7:0]  skid_x_q, skid_x_d;
  logic [6:0]  skid_y_q, skid_y_d;
  logic [2:0]  skid_dat_q, skid_dat_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_x_q, out_x_d;
  logic [6:0]  out_y_q, out_y_d;
  logic [2:0]  out_colour_q, out_colour_d;
  logic        done_q, done_d;
  logic        oob_q, oob_d;

  logic          wr_in_range, wr_en, rd_issue, xfer, last_out;
  logic [AW-1:0] wr_addr;
  logic [1:0]    occ;

  assign wr_in_range = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  assign wr_en       = vga_plot && wr_in_range;
  assign wr_addr     = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
  assign xfer        = out_valid_q && out_ready;
  assign last_out    = (out_x_q == 8'(WIDTH - 1)) && (out_y_q == 7'(HEIGHT - 1));

  // Registered read before write: a same-cycle write to the read address returns the old pixel.
  always_ff @(posedge clk) begin
    if (wr_en) fb_mem[wr_addr] <= vga_colour;
    if (rd_issue) rd_dat_q <= fb_mem[rd_addr_q];
  end

  always_comb begin
    state_d      = state_q;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    rd_addr_d    = rd_addr_q;
    rd_all_d     = rd_all_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    skid_vld_d   = skid_vld_q;
    skid_x_d     = skid_x_q;
    skid_y_d     = skid_y_q;
    skid_dat_d   = skid_dat_q;
    out_valid_d  = out_valid_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    done_d       = done_q;
    oob_d        = oob_q | (vga_plot & ~wr_in_range);
    rd_issue     = 1'b0;
    // Slots held after this edge; reads are only issued when a landing slot is guaranteed.
    occ = 2'(out_valid_q) + 2'(skid_vld_q) + 2'(pend_q) - 2'(xfer);

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        if (start) begin
          state_d    = PRIME;
          rd_x_d     = '0;
          rd_y_d     = '0;
          rd_addr_d  = '0;
          rd_all_d   = 1'b0;
          skid_vld_d = 1'b0;
        end
      end
      PRIME: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          rd_issue = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (!start) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          skid_vld_d  = 1'b0;
        end else if (xfer && last_out) begin
          state_d     = DONE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          rd_issue = !rd_all_q && (occ < 2'd2);
          if (!out_valid_q || xfer) begin
            if (skid_vld_q) begin
              out_valid_d  = 1'b1;
              out_x_d      = skid_x_q;
              out_y_d      = skid_y_q;
              out_colour_d = skid_dat_q;
              skid_vld_d   = pend_q;
              skid_x_d     = pend_x_q;
              skid_y_d     = pend_y_q;
              skid_dat_d   = rd_dat_q;
            end else if (pend_q) begin
              out_valid_d  = 1'b1;
              out_x_d      = pend_x_q;
              out_y_d      = pend_y_q;
              out_colour_d = rd_dat_q;
            end else begin
              out_valid_d = 1'b0;
            end
          end else if (pend_q) begin
            skid_vld_d = 1'b1;
            skid_x_d   = pend_x_q;
            skid_y_d   = pend_y_q;
            skid_dat_d = rd_dat_q;
          end
        end
      end
      DONE: begin
        done_d = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pend_d = rd_issue;
    if (rd_issue) begin
      pend_x_d  = rd_x_q;
      pend_y_d  = rd_y_q;
      rd_addr_d = rd_addr_q + 1'b1;
      if (rd_x_q == 8'(WIDTH - 1)) begin
        rd_x_d = '0;
        if (rd_y_q == 7'(HEIGHT - 1)) rd_all_d = 1'b1;
        else rd_y_d = rd_y_q + 1'b1;
      end else begin
        rd_x_d = rd_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      rd_addr_q    <= '0;
      rd_all_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      skid_vld_q   <= 1'b0;
      skid_x_q     <= '0;
      skid_y_q     <= '0;
      skid_dat_q   <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      done_q       <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      rd_addr_q    <= rd_addr_d;
      rd_all_q     <= rd_all_d;
      pend_q       <= pend_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      skid_vld_q   <= skid_vld_d;
      skid_x_q     <= skid_x_d;
      skid_y_q     <= skid_y_d;
      skid_dat_q   <= skid_dat_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      done_q       <= done_d;
      oob_q        <= oob_d;
    end
  end

  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign oob_err    = oob_q;

`ifdef PLOT_READBACK_COUNT_EN
  logic [14:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && (cnt_q != 15'h7fff)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign plot_count = cnt_q;
`endif

endmodule

// File: tb/tb_plot_readback.sv
// Scoreboard bench for plot_readback: model framebuffer, expected pixels queued at dump start.
module tb_plot_readback;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       start;
  logic       done;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_valid;
  logic       out_ready;
  logic       oob_err;
`ifdef PLOT_READBACK_COUNT_EN
  logic [14:0] plot_count;
`endif

  plot_readback #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .start(start), .done(done),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
    .out_valid(out_valid), .out_ready(out_ready), .oob_err(oob_err)
`ifdef PLOT_READBACK_COUNT_EN
    , .plot_count(plot_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  logic [2:0] model [0:W*H-1];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_cnt  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
    @(posedge clk); #1;
    vga_plot = 1'b0;
    if (x < W && y < H) begin
      model[y*W + x] = 3'(c);
      exp_cnt++;
    end
  endtask

  // Runs a dump for n transfers; caller decides how it ends (done, abort, reset).
  task automatic dump(input int n, input bit rnd, input bit chk_lat);
    int   cyc, got;
    bit   stalled;
    pix_t held, e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.x = 8'(i % W); e.y = 7'(i / W); e.c = model[i];
      exp_q.push_back(e);
    end
    start = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    // start is sampled on the first edge; out_valid rises two edges after that.
    if (chk_lat) check("first_valid_latency", cyc, 3);
    got = 0; stalled = 1'b0; cyc = 0; held = '0;
    while (got < n && cyc < 4*n + 100) begin
      if (stalled)
        check("stall_hold", {out_valid, out_x, out_y, out_colour}, {1'b1, held});
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          e = exp_q.pop_front();
          check("pixel", {out_x, out_y, out_colour}, e);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {out_x, out_y, out_colour};
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < n) check("dump_timeout", got, n);
  endtask

  task automatic abort_check(input string tag);
    start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {done, out_valid, out_x, out_y, out_colour, oob_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill: column sweep, colour = x[2:0].
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        plot(x, y, x % 8);
    check("fill_oob_clear", int'(oob_err), 0);
`ifdef PLOT_READBACK_COUNT_EN
    check("fill_count", int'(plot_count), exp_cnt);
`endif
    dump(W*H, 1'b0, 1'b1);
    check("full_done", int'(done), 1);
    check("full_valid_low", int'(out_valid), 0);
    @(posedge clk); #1;
    check("done_held", int'(done), 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_drop", int'(done), 0);

    // Backpressure with (5,0)=6, then abort after 50 and restart at (0,0).
    plot(5, 0, 6);
    dump(50, 1'b1, 1'b1);
    abort_check("abort");
    repeat (2) @(posedge clk);
    #1;
    dump(20, 1'b0, 1'b1);
    abort_check("abort2");

    // Out of range plots: no write, sticky error.
    plot(160, 0, 7);
    plot(0, 120, 7);
    check("oob_set", int'(oob_err), 1);
`ifdef PLOT_READBACK_COUNT_EN
    check("oob_count", int'(plot_count), exp_cnt);
`endif
    dump(2*W + 5, 1'b1, 1'b0);
    abort_check("oob_abort");
    check("oob_sticky", int'(oob_err), 1);

    // Concurrent writes: (10,10) well ahead of its read; (40,6) on its read-issue edge.
    // Pixel n is read on edge n+1 counted from the start-sampling edge 0.
    model[10*W + 10] = 3'd1;
    exp_cnt = exp_cnt - 1;
    fork
      dump(11*W, 1'b0, 1'b1);
      begin
        repeat (100) @(posedge clk);
        #1;
        plot(10, 10, 1);
        repeat (900) @(posedge clk);
        #1;
        vga_x = 8'd40; vga_y = 7'd6; vga_colour = 3'd7; vga_plot = 1'b1;
        @(posedge clk); #1;
        vga_plot = 1'b0;
      end
    join
    abort_check("conc_abort");
    model[6*W + 40] = 3'd7;
    exp_cnt++;
`ifdef PLOT_READBACK_COUNT_EN
    check("conc_count", int'(plot_count), exp_cnt);
`endif

    // Async reset mid-stream, off a clock edge.
    dump(30, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {done, out_valid, out_x, out_y, out_colour, oob_err}, 0);
    start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef PLOT_READBACK_COUNT_EN
    check("arst_count", int'(plot_count), 0);
`endif
    dump(7*W, 1'b0, 1'b1);
    abort_check("final_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
